// File: rtl/everloop_ctrl.sv
// everloop_ctrl: fetches LED bytes from an image RAM one at a time, hands
// each byte to a serializer on request, then holds the serial line low for
// a latch gap before signalling frame completion.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start, auto_refresh  frame request pulse / continuous refresh enable
//   ram_addr, ram_rd     image RAM byte address and read strobe
//   ram_data             image RAM data, valid the cycle after ram_rd
//   en_rd                byte request pulse from the serializer
//   data_RGB, ack        byte to serializer and its load pulse
//   reset_everloop       forces the serial line low (idle / latch gap)
//   busy, frame_done     frame in progress / end-of-latch pulse
//   underrun             sticky: byte requested with none staged
module everloop_ctrl #(
  parameter int unsigned N_LEDS        = 35,
  parameter int unsigned BYTES_PER_LED = 4,
  parameter int unsigned LATCH_CYCLES  = 16'd15000,
  parameter int unsigned AW            = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          auto_refresh,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_data,
  input  logic          en_rd,
  output logic [7:0]    data_RGB,
  output logic          ack,
  output logic          reset_everloop,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);

  localparam int unsigned NBYTES = N_LEDS * BYTES_PER_LED;
  localparam int unsigned CW     = $clog2(LATCH_CYCLES + 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NBYTES - 1);
  localparam logic [CW-1:0] LATCH_TOP = CW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STAGE,
    WAIT_REQ,
    DRAIN,
    LATCH
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic          staged, staged_n;
  logic [7:0]    hold, hold_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] ram_addr_n;
  logic          ram_rd_n;
  logic [7:0]    data_n;
  logic          ack_n;
  logic          reset_everloop_n;
  logic          busy_n;
  logic          frame_done_n;
  logic          underrun_n;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      idx            <= '0;
      staged         <= 1'b0;
      hold           <= '0;
      cnt            <= '0;
      ram_addr       <= '0;
      ram_rd         <= 1'b0;
      data_RGB       <= '0;
      ack            <= 1'b0;
      reset_everloop <= 1'b1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      staged         <= staged_n;
      hold           <= hold_n;
      cnt            <= cnt_n;
      ram_addr       <= ram_addr_n;
      ram_rd         <= ram_rd_n;
      data_RGB       <= data_n;
      ack            <= ack_n;
      reset_everloop <= reset_everloop_n;
      busy           <= busy_n;
      frame_done     <= frame_done_n;
      underrun       <= underrun_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    staged_n   = staged;
    hold_n     = hold;
    cnt_n      = cnt;
    ram_addr_n = ram_addr;
    data_n     = data_RGB;
    underrun_n = underrun;
    ack_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start || auto_refresh) begin
          state_n  = FETCH;
          idx_n    = '0;
          staged_n = 1'b0;
          // Only an explicit request acknowledges a previous underrun
          if (start) underrun_n = 1'b0;
        end
      end
      FETCH: begin
        state_n = STAGE;
        if (en_rd) underrun_n = 1'b1;
      end
      STAGE: begin
        hold_n   = ram_data;
        staged_n = 1'b1;
        state_n  = WAIT_REQ;
        if (en_rd) underrun_n = 1'b1;
      end
      WAIT_REQ: begin
        if (en_rd) begin
          if (staged) begin
            ack_n    = 1'b1;
            data_n   = hold;
            staged_n = 1'b0;
            if (idx == LAST_IDX) begin
              state_n = DRAIN;
            end else begin
              idx_n   = idx + AW'(1);
              state_n = FETCH;
            end
          end else begin
            underrun_n = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Next request means the last byte has left the shifter
        if (en_rd) begin
          state_n = LATCH;
          cnt_n   = LATCH_TOP;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          if (auto_refresh) begin
            state_n = FETCH;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Moore-style outputs, registered alongside the state they describe
    ram_rd_n         = (state_n == FETCH);
    if (state_n == FETCH) ram_addr_n = idx_n;
    reset_everloop_n = (state_n == IDLE) || (state_n == LATCH);
    busy_n           = (state_n != IDLE);
    frame_done_n     = (state_n == LATCH) && (cnt_n == '0);
  end

endmodule

// File: doc/everloop_ctrl.md
EVERLOOP_CTRL -- requirements
Module: everloop_ctrl

Interface
REQ-001 Parameter N_LEDS, default 35: number of LEDs in the ring.
REQ-002 Parameter BYTES_PER_LED, default 4: bytes per LED (R,G,B,W order as stored in RAM).
REQ-003 Parameter LATCH_CYCLES, default 16'd15000: cycles the line is held low after a frame.
REQ-004 Parameter AW, default 8: image RAM address width; N_LEDS*BYTES_PER_LED SHALL be at most 2**AW.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle frame request.
REQ-008 auto_refresh  input  1  when high, a new frame starts automatically after each latch gap.
REQ-009 ram_addr  output  AW  image RAM byte address.
REQ-010 ram_rd  output  1  image RAM read strobe; data valid on ram_data one cycle later.
REQ-011 ram_data  input  8  image RAM read data.
REQ-012 en_rd  input  1  byte request pulse from serializer.
REQ-013 data_RGB  output  8  byte to serializer.
REQ-014 ack  output  1  single-cycle pulse: data_RGB valid, serializer loads it.
REQ-015 reset_everloop  output  1  forces serial line low (latch gap / idle).
REQ-016 busy  output  1  high from frame start until frame_done.
REQ-017 frame_done  output  1  single-cycle pulse at end of latch gap.
REQ-018 underrun  output  1  sticky error: en_rd received with no byte staged.

Function
REQ-019 FSM states: IDLE, FETCH, STAGE, WAIT_REQ, DRAIN, LATCH.
REQ-020 IDLE: reset_everloop=1, busy=0; start=1 or auto_refresh=1 -> FETCH with byte index 0.
REQ-021 FETCH: ram_rd=1 for exactly one cycle with ram_addr=byte index -> STAGE.
REQ-022 STAGE: capture ram_data into holding register, set staged flag -> WAIT_REQ.
REQ-023 WAIT_REQ: on en_rd with staged=1, data_RGB=holding register and ack=1 in the same cycle, staged cleared, index incremented; if index was last (N_LEDS*BYTES_PER_LED-1) -> DRAIN, else -> FETCH.
REQ-024 reset_everloop SHALL be 0 in FETCH, STAGE, WAIT_REQ, DRAIN.
REQ-025 DRAIN: wait for next en_rd (last byte fully shifted), ack stays 0 -> LATCH.
REQ-026 LATCH: reset_everloop=1 for exactly LATCH_CYCLES cycles; on final cycle frame_done=1; then -> FETCH (index 0) if auto_refresh=1, else IDLE.
REQ-027 en_rd in WAIT_REQ with staged=0, or in FETCH/STAGE: underrun set, no ack issued, state unchanged; underrun cleared only by reset or a start pulse in IDLE.
REQ-028 start while busy=1 SHALL be ignored; no queued request.
REQ-029 en_rd in IDLE or LATCH SHALL be ignored (no ack, no underrun).
REQ-030 ack SHALL never be high on two consecutive cycles; at most one ack per en_rd.
REQ-031 Byte index SHALL not exceed N_LEDS*BYTES_PER_LED-1; no wrap within a frame.
REQ-032 Latency start -> first byte staged: 3 cycles (IDLE, FETCH, STAGE).
REQ-033 Latch counter width SHALL hold LATCH_CYCLES without overflow.

Reset
REQ-034 rst low SHALL asynchronously force: state IDLE, index 0, staged 0, ram_addr 0, ram_rd 0, data_RGB 0, ack 0, reset_everloop 1, busy 0, frame_done 0, underrun 0.
REQ-035 rst asserted mid-frame SHALL abort the frame; after release the block stays IDLE until start or auto_refresh.

Verification
REQ-036 N_LEDS=2, BYTES_PER_LED=4, RAM 0x10..0x17, start pulse, en_rd every 2000 cycles -> ack with data_RGB 0x10..0x17 in order, one ack per en_rd, frame_done after 9th en_rd plus LATCH_CYCLES.
REQ-037 start, en_rd on cycle 2 after start (before STAGE complete) -> underrun=1, no ack; later en_rd -> ack with byte 0.
REQ-038 auto_refresh=1 held -> second frame FETCH at index 0 one cycle after frame_done; reset_everloop low again.
REQ-039 start pulses during busy -> no extra frame; exactly one frame_done.
REQ-040 rst low during WAIT_REQ at byte 5 -> all outputs at REQ-034 values immediately; start after release replays from byte 0.
REQ-041 LATCH_CYCLES=4 -> reset_everloop high exactly 4 cycles between DRAIN exit and frame_done cycle inclusive.
